// File: rtl/ibex_pkg.sv
// Shared definitions for the register-file port sequencer.
//   RF_ADDR_W      : register-file address width
//   rf_seq_state_e : debug access FSM states
package ibex_pkg;

    localparam int unsigned RF_ADDR_W = 5;

    typedef enum logic [1:0] {
        StIdle,
        StPendWr,
        StPendRd,
        StResp
    } rf_seq_state_e;

endpackage

// File: rtl/ibex_rf_seq_stall_cnt.sv
// Saturating count of consecutive cycles a debug access has been blocked.
// Ports:
//   clk_int, rst_ni : clock, asynchronous active-low reset
//   inc_i           : access blocked this cycle
//   clr_i           : no access pending, restart the count
//   stall_o         : count has reached StallLimit
module ibex_rf_seq_stall_cnt #(
    parameter int unsigned StallLimit = 8
) (
    input  logic clk_int,
    input  logic rst_ni,
    input  logic inc_i,
    input  logic clr_i,
    output logic stall_o
);

    localparam int unsigned CntW = $clog2(StallLimit + 1);
    localparam logic [CntW-1:0] Limit = CntW'(StallLimit);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != Limit)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_int or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stall_o = (cnt_q == Limit);

endmodule

// File: rtl/ibex_rf_port_sequencer.sv
// Initiator side of the 1W/2R register-file port interface. Core writeback and
// read-port-B address pass straight through; debug reads/writes are slotted into
// cycles where the core leaves the relevant port idle, with a req/gnt/rvalid
// handshake toward the debug module and a stall request if debug starves.
// Ports:
//   wb_*           : core writeback (write port)
//   id_*           : core ID-stage read port B usage/address
//   dbg_*          : debug-module access request and response
//   core_stall_req_o : asks the core to free its ports
//   rf_*           : to/from the register file
module ibex_rf_port_sequencer
    import ibex_pkg::*;
#(
    parameter bit          RV32E      = 1'b0,
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned StallLimit = 8
) (
    input  logic                 clk_int,
    input  logic                 rst_ni,
    input  logic                 wb_we_i,
    input  logic [RF_ADDR_W-1:0] wb_waddr_i,
    input  logic [DataWidth-1:0] wb_wdata_i,
    input  logic                 id_rb_used_i,
    input  logic [RF_ADDR_W-1:0] id_raddr_b_i,
    input  logic                 dbg_req_i,
    input  logic                 dbg_we_i,
    input  logic [RF_ADDR_W-1:0] dbg_addr_i,
    input  logic [DataWidth-1:0] dbg_wdata_i,
    output logic                 dbg_gnt_o,
    output logic                 dbg_rvalid_o,
    output logic [DataWidth-1:0] dbg_rdata_o,
    output logic                 dbg_err_o,
    output logic                 core_stall_req_o,
    output logic                 rf_we_o,
    output logic [RF_ADDR_W-1:0] rf_waddr_o,
    output logic [DataWidth-1:0] rf_wdata_o,
    output logic [RF_ADDR_W-1:0] rf_raddr_b_o,
    input  logic [DataWidth-1:0] rf_rdata_b_i
);

    rf_seq_state_e        state_q, state_d;
    logic                 we_q, we_d;
    logic                 err_q, err_d;
    logic [RF_ADDR_W-1:0] addr_q, addr_d;
    logic [DataWidth-1:0] wdata_q, wdata_d;
    logic [DataWidth-1:0] rdata_q, rdata_d;

    logic                 gnt, rvalid, blocked, pend, stall;
    logic                 rf_we;
    logic [RF_ADDR_W-1:0] rf_waddr, rf_raddr_b;
    logic [DataWidth-1:0] rf_wdata;

    assign pend = (state_q == StPendWr) || (state_q == StPendRd);

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        err_d      = err_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        gnt        = 1'b0;
        rvalid     = 1'b0;
        blocked    = 1'b0;
        rf_we      = wb_we_i;
        rf_waddr   = wb_waddr_i;
        rf_wdata   = wb_wdata_i;
        rf_raddr_b = id_raddr_b_i;

        unique case (state_q)
            StIdle: begin
                gnt = dbg_req_i;
                if (dbg_req_i) begin
                    we_d    = dbg_we_i;
                    addr_d  = dbg_addr_i;
                    wdata_d = dbg_wdata_i;
                    rdata_d = '0;
                    err_d   = RV32E && dbg_addr_i[RF_ADDR_W-1];
                    if (RV32E && dbg_addr_i[RF_ADDR_W-1]) begin
                        state_d = StResp;
                    end else begin
                        state_d = dbg_we_i ? StPendWr : StPendRd;
                    end
                end
            end
            StPendWr: begin
                // Core owns the write port whenever it wants it.
                if (wb_we_i) begin
                    blocked = 1'b1;
                end else begin
                    rf_we    = (addr_q != '0);
                    rf_waddr = addr_q;
                    rf_wdata = wdata_q;
                    state_d  = StResp;
                end
            end
            StPendRd: begin
                if (id_rb_used_i) begin
                    blocked = 1'b1;
                end else begin
                    rf_raddr_b = addr_q;
                    rdata_d    = rf_rdata_b_i;
                    state_d    = StResp;
                end
            end
            StResp: begin
                rvalid  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_int or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    ibex_rf_seq_stall_cnt #(
        .StallLimit(StallLimit)
    ) u_stall_cnt (
        .clk_int(clk_int),
        .rst_ni (rst_ni),
        .inc_i  (blocked),
        .clr_i  (!pend),
        .stall_o(stall)
    );

    // Outputs are forced low while reset is held, including the pass-through paths.
    assign dbg_gnt_o        = rst_ni & gnt;
    assign dbg_rvalid_o     = rst_ni & rvalid;
    assign dbg_err_o        = rst_ni & rvalid & err_q;
    assign dbg_rdata_o      = (rst_ni && rvalid && !we_q && !err_q) ? rdata_q : '0;
    assign core_stall_req_o = rst_ni & pend & stall;
    assign rf_we_o          = rst_ni & rf_we;
    assign rf_waddr_o       = rst_ni ? rf_waddr : '0;
    assign rf_wdata_o       = rst_ni ? rf_wdata : '0;
    assign rf_raddr_b_o     = rst_ni ? rf_raddr_b : '0;

endmodule

// File: tb/tb_ibex_rf_port_sequencer.sv
// Self-checking bench for ibex_rf_port_sequencer (RV32E=1, StallLimit=4) with a
// behavioural register file attached to the RF ports.
module tb_ibex_rf_port_sequencer;

    localparam int unsigned StallLimit = 4;

    logic        clk_int;
    logic        rst_ni;
    logic        wb_we_i;
    logic [4:0]  wb_waddr_i;
    logic [31:0] wb_wdata_i;
    logic        id_rb_used_i;
    logic [4:0]  id_raddr_b_i;
    logic        dbg_req_i;
    logic        dbg_we_i;
    logic [4:0]  dbg_addr_i;
    logic [31:0] dbg_wdata_i;
    logic        dbg_gnt_o;
    logic        dbg_rvalid_o;
    logic [31:0] dbg_rdata_o;
    logic        dbg_err_o;
    logic        core_stall_req_o;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic [4:0]  rf_raddr_b_o;
    logic [31:0] rf_rdata_b_i;

    ibex_rf_port_sequencer #(
        .RV32E     (1'b1),
        .DataWidth (32),
        .StallLimit(StallLimit)
    ) dut (
        .clk_int         (clk_int),
        .rst_ni          (rst_ni),
        .wb_we_i         (wb_we_i),
        .wb_waddr_i      (wb_waddr_i),
        .wb_wdata_i      (wb_wdata_i),
        .id_rb_used_i    (id_rb_used_i),
        .id_raddr_b_i    (id_raddr_b_i),
        .dbg_req_i       (dbg_req_i),
        .dbg_we_i        (dbg_we_i),
        .dbg_addr_i      (dbg_addr_i),
        .dbg_wdata_i     (dbg_wdata_i),
        .dbg_gnt_o       (dbg_gnt_o),
        .dbg_rvalid_o    (dbg_rvalid_o),
        .dbg_rdata_o     (dbg_rdata_o),
        .dbg_err_o       (dbg_err_o),
        .core_stall_req_o(core_stall_req_o),
        .rf_we_o         (rf_we_o),
        .rf_waddr_o      (rf_waddr_o),
        .rf_wdata_o      (rf_wdata_o),
        .rf_raddr_b_o    (rf_raddr_b_o),
        .rf_rdata_b_i    (rf_rdata_b_i)
    );

    initial clk_int = 1'b0;
    always #5 clk_int = ~clk_int;

    int cyc = 0;
    always @(posedge clk_int) cyc <= cyc + 1;

    // Behavioural RF: x0 reads zero, write on clock edge, combinational read.
    logic [31:0] rf [32];
    logic        preload;
    always @(posedge clk_int) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) rf[i] <= (i == 0) ? 32'h0 : 32'h1000_0000 + 32'(i);
        end else if (rf_we_o && rf_waddr_o != 5'd0) begin
            rf[rf_waddr_o] <= rf_wdata_o;
        end
    end
    assign rf_rdata_b_i = rf[rf_raddr_b_o];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    // Response scoreboard: every rvalid must match the oldest outstanding expectation.
    always @(negedge clk_int) begin
        if (dbg_rvalid_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rvalid_unexpected: got rvalid=1, expected 0 (cycle %0d)", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_err", 32'(dbg_err_o), 32'(mon_e.err));
                chk("rsp_rdata", dbg_rdata_o, mon_e.rdata);
                chk("rsp_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        int          blk;       // cycles the core keeps the needed port busy
        logic        issue_wb;  // core writes the same register in the read issue cycle
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    localparam int NumVec = 13;
    vec_t vecs[NumVec];

    task automatic wait_rsp();
        for (int k = 0; k < 6 && exp_q.size() != 0; k++) @(posedge clk_int);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rsp_timeout: got %0d outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        @(posedge clk_int); #1;
        dbg_req_i   = 1'b1;
        dbg_we_i    = v.we;
        dbg_addr_i  = v.addr;
        dbg_wdata_i = v.wdata;
        if (v.blk > 0) begin
            if (v.we) begin
                wb_we_i    = 1'b1;
                wb_waddr_i = 5'd1;
                wb_wdata_i = 32'h1111_1111;
            end else begin
                id_rb_used_i = 1'b1;
                id_raddr_b_i = 5'd2;
            end
        end
        @(negedge clk_int);
        chk("gnt", 32'(dbg_gnt_o), 32'd1);
        if (v.exp_err) begin
            e.err = 1'b1; e.rdata = 32'h0; e.cyc = cyc + 1;
            exp_q.push_back(e);
        end
        @(posedge clk_int); #1;
        dbg_req_i = 1'b0;
        if (v.exp_err) begin
            @(negedge clk_int);
            chk("err_no_rf_write", 32'(rf_we_o), 32'd0);
        end else begin
            for (int j = 0; j < v.blk; j++) begin
                @(negedge clk_int);
                chk("blocked_stall", 32'(core_stall_req_o), 32'(j >= int'(StallLimit)));
                if (v.we) begin
                    chk("core_wins_we", 32'(rf_we_o), 32'd1);
                    chk("core_wins_waddr", 32'(rf_waddr_o), 32'd1);
                end else begin
                    chk("core_wins_raddr", 32'(rf_raddr_b_o), 32'd2);
                end
                @(posedge clk_int); #1;
            end
            wb_we_i      = 1'b0;
            id_rb_used_i = 1'b0;
            if (v.issue_wb) begin
                wb_we_i    = 1'b1;
                wb_waddr_i = v.addr;
                wb_wdata_i = 32'hCAFE_F00D;
            end
            @(negedge clk_int);
            chk("issue_stall", 32'(core_stall_req_o), 32'(v.blk >= int'(StallLimit)));
            if (v.we) begin
                chk("issue_we", 32'(rf_we_o), 32'(v.addr != 5'd0));
                if (v.addr != 5'd0) begin
                    chk("issue_waddr", 32'(rf_waddr_o), 32'(v.addr));
                    chk("issue_wdata", rf_wdata_o, v.wdata);
                end
            end else begin
                chk("issue_raddr", 32'(rf_raddr_b_o), 32'(v.addr));
                if (v.issue_wb) chk("issue_core_we", 32'(rf_we_o), 32'd1);
            end
            e.err = 1'b0; e.rdata = v.exp_rdata; e.cyc = cyc + 1;
            exp_q.push_back(e);
            @(posedge clk_int); #1;
            wb_we_i = 1'b0;
            @(negedge clk_int);
            chk("resp_stall_clear", 32'(core_stall_req_o), 32'd0);
        end
        wait_rsp();
    endtask

    initial begin
        //          we    addr    wdata          blk iwb   err   rdata
        vecs[0]  = '{1'b1, 5'd5,  32'hDEAD_BEEF, 0, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 5'd5,  32'h0,         0, 1'b0, 1'b0, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b0, 5'd7,  32'h0,         3, 1'b0, 1'b0, 32'h1000_0007};
        vecs[3]  = '{1'b1, 5'd9,  32'h0000_A5A5, 6, 1'b0, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 5'd1,  32'h0,         0, 1'b0, 1'b0, 32'h1111_1111};
        vecs[5]  = '{1'b0, 5'd9,  32'h0,         0, 1'b0, 1'b0, 32'h0000_A5A5};
        vecs[6]  = '{1'b0, 5'd16, 32'h0,         0, 1'b0, 1'b1, 32'h0};
        vecs[7]  = '{1'b1, 5'd0,  32'h0000_1234, 0, 1'b0, 1'b0, 32'h0};
        vecs[8]  = '{1'b0, 5'd0,  32'h0,         0, 1'b0, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 5'd3,  32'h0,         0, 1'b1, 1'b0, 32'h1000_0003};
        vecs[10] = '{1'b0, 5'd3,  32'h0,         0, 1'b0, 1'b0, 32'hCAFE_F00D};
        vecs[11] = '{1'b1, 5'd20, 32'h5555_5555, 0, 1'b0, 1'b1, 32'h0};
        vecs[12] = '{1'b0, 5'd4,  32'h0,         0, 1'b0, 1'b0, 32'h1000_0004};

        preload      = 1'b1;
        rst_ni       = 1'b0;
        wb_we_i      = 1'b1;
        wb_waddr_i   = 5'd6;
        wb_wdata_i   = 32'hFFFF_FFFF;
        id_rb_used_i = 1'b0;
        id_raddr_b_i = 5'd3;
        dbg_req_i    = 1'b1;
        dbg_we_i     = 1'b0;
        dbg_addr_i   = 5'd0;
        dbg_wdata_i  = 32'h0;
        repeat (2) @(negedge clk_int);
        chk("rst_gnt", 32'(dbg_gnt_o), 32'd0);
        chk("rst_rvalid", 32'(dbg_rvalid_o), 32'd0);
        chk("rst_rf_we", 32'(rf_we_o), 32'd0);
        chk("rst_rf_waddr", 32'(rf_waddr_o), 32'd0);
        chk("rst_rf_raddr", 32'(rf_raddr_b_o), 32'd0);
        chk("rst_stall", 32'(core_stall_req_o), 32'd0);
        wb_we_i   = 1'b0;
        dbg_req_i = 1'b0;
        @(posedge clk_int); #1;
        preload = 1'b0;
        rst_ni  = 1'b1;

        // Pass-through with no debug activity.
        @(posedge clk_int); #1;
        wb_we_i      = 1'b1;
        wb_waddr_i   = 5'd12;
        wb_wdata_i   = 32'h5A5A_0000;
        id_raddr_b_i = 5'd13;
        @(negedge clk_int);
        chk("pt_we", 32'(rf_we_o), 32'd1);
        chk("pt_waddr", 32'(rf_waddr_o), 32'd12);
        chk("pt_wdata", rf_wdata_o, 32'h5A5A_0000);
        chk("pt_raddr", 32'(rf_raddr_b_o), 32'd13);
        chk("pt_rdata", rf_rdata_b_i, 32'h1000_000D);
        @(posedge clk_int); #1;
        wb_we_i      = 1'b0;
        id_raddr_b_i = 5'd0;

        for (int i = 0; i < NumVec; i++) run_vec(vecs[i]);

        // Reset while a debug read is pending: access dropped, no late rvalid.
        @(posedge clk_int); #1;
        dbg_req_i    = 1'b1;
        dbg_we_i     = 1'b0;
        dbg_addr_i   = 5'd11;
        id_rb_used_i = 1'b1;
        id_raddr_b_i = 5'd2;
        @(negedge clk_int);
        chk("rstmid_gnt", 32'(dbg_gnt_o), 32'd1);
        @(posedge clk_int); #1;
        dbg_req_i = 1'b0;
        repeat (2) @(posedge clk_int);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("rstmid_raddr", 32'(rf_raddr_b_o), 32'd0);
        chk("rstmid_stall", 32'(core_stall_req_o), 32'd0);
        chk("rstmid_rvalid", 32'(dbg_rvalid_o), 32'd0);
        id_rb_used_i = 1'b0;
        repeat (2) @(posedge clk_int);
        #1;
        rst_ni = 1'b1;
        repeat (4) @(posedge clk_int);
        run_vec('{1'b0, 5'd11, 32'h0, 0, 1'b0, 1'b0, 32'h1000_000B});

        repeat (2) @(posedge clk_int);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
